vga_scan_reader: RTL

- Display-side consumer of the SDRAM-to-VGA dual-clock FIFO, running entirely in the clk_100M domain.
- Generates 640x480@60 VGA timing from a divided pixel enable and issues vga_rdfifo one pixel ahead of each active pixel.
- Drives registered RGB565 and sync outputs.
- Holds the display blank until the FIFO is primed, then runs continuously. Flags underflow and pulses frame_end so the SDRAM side can re-arm its frame address.

---
 rtl/vga_scan_reader_if.sv | 22 ++
 rtl/vga_scan_reader.sv | 128 ++++++++++++
 2 files changed

// File: rtl/vga_scan_reader_if.sv
// Read side of the SDRAM-to-VGA dual-clock FIFO as seen from the display domain.
// master = the pixel consumer issuing rdreq, slave = the FIFO presenting q/flags.
interface vga_scan_reader_if;
    logic [15:0] data_vga;
    logic        rd_empty;
    logic [10:0] rd_used;
    logic        vga_rdfifo;

    modport master (
        input  data_vga,
        input  rd_empty,
        input  rd_used,
        output vga_rdfifo
    );

    modport slave (
        output data_vga,
        output rd_empty,
        output rd_used,
        input  vga_rdfifo
    );
endinterface

// File: rtl/vga_scan_reader.sv
// VGA timing generator that pulls one FIFO word per active pixel and drives registered RGB565/sync.
// A pixel read on cycle T is registered onto the outputs at the edge closing T+1, when FIFO q is valid.
module vga_scan_reader #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int PIX_DIV   = 4,
    parameter int PRIME_LVL = 512
) (
    input  logic              clk_100M,
    input  logic              rst_100i,
    vga_scan_reader_if.master fifo,
    output logic [4:0]        vga_r,
    output logic [5:0]        vga_g,
    output logic [4:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_de,
    output logic              frame_end,
    output logic              underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0]   H_ACT_C  = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0]   HS_BEG   = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0]   HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0]   V_ACT_C  = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0]   VS_BEG   = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0]   VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [10:0]      PRIME_C  = 11'(PRIME_LVL);

    typedef enum logic {PRIME, RUN} state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [H_W-1:0]   h_cnt;
    logic [V_W-1:0]   v_cnt;
    logic             pix_en;
    logic             go;
    logic             active;

    logic             vld_p0;
    logic             de_p0;
    logic             hs_p0;
    logic             vs_p0;
    logic             empty_p0;

    // The priming pix_en already serves pixel (0,0), so reads start on that same cycle.
    always_comb begin
        pix_en = (div_cnt == DIV_LAST);
        go     = pix_en && ((state == RUN) || (fifo.rd_used >= PRIME_C));
        active = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    end

    assign fifo.vga_rdfifo = go && active;
    assign frame_end       = go && (h_cnt == '0) && (v_cnt == V_ACT_C);

    always_ff @(posedge clk_100M or negedge rst_100i) begin
        if (!rst_100i) begin
            state     <= PRIME;
            div_cnt   <= '0;
            h_cnt     <= '0;
            v_cnt     <= '0;
            vld_p0    <= 1'b0;
            de_p0     <= 1'b0;
            hs_p0     <= 1'b1;
            vs_p0     <= 1'b1;
            empty_p0  <= 1'b0;
            vga_r     <= '0;
            vga_g     <= '0;
            vga_b     <= '0;
            vga_hs    <= 1'b1;
            vga_vs    <= 1'b1;
            vga_de    <= 1'b0;
            underflow <= 1'b0;
        end else begin
            div_cnt <= pix_en ? '0 : div_cnt + 1'b1;
            vld_p0  <= go;

            // p0: pixel timing captured on the read cycle
            if (go) begin
                state    <= RUN;
                de_p0    <= active;
                hs_p0    <= !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
                vs_p0    <= !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
                empty_p0 <= fifo.rd_empty;
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end

            // p1: outputs, with FIFO q now valid
            if (vld_p0) begin
                vga_de <= de_p0;
                vga_hs <= hs_p0;
                vga_vs <= vs_p0;
                if (de_p0 && !empty_p0) begin
                    vga_r <= fifo.data_vga[15:11];
                    vga_g <= fifo.data_vga[10:5];
                    vga_b <= fifo.data_vga[4:0];
                end else begin
                    vga_r <= '0;
                    vga_g <= '0;
                    vga_b <= '0;
                end
                if (de_p0 && empty_p0)
                    underflow <= 1'b1;
            end
        end
    end

endmodule
